fetch_sequencer: RTL

- Instruction-fetch stage sitting directly upstream of the flow-control stage.
- Owns the architectural PC and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Presents each fetched word to decode/execute over a valid/ready handshake.
- Waits for the flow-control commit (next PC plus exception flag) before fetching again. Strictly one instruction in flight; no prediction.

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Single-issue instruction fetch stage: owns the PC, fetches over req/ack, hands off over valid/ready.
// Optional macro FETCH_ALIGN_CHECK_EN: halt with fault=3 on a misaligned committed PC instead of masking it.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TIMEOUT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        commit,
   input  logic [31:0] new_pc,
   input  logic        flow_exception,
   output logic        halted,
   output logic [1:0]  fault
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      HOLD,
      EXEC,
      HALT
   } state_t;

   localparam logic [1:0] FAULT_EXC     = 2'd1;
   localparam logic [1:0] FAULT_TIMEOUT = 2'd2;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [1:0] FAULT_ALIGN   = 2'd3;
`endif

   // Limit is compared against the count before this cycle's increment, so
   // the MEM_TIMEOUT-th ack-less FETCH cycle is the one that faults.
   localparam bit          TO_EN   = (MEM_TIMEOUT != 0);
   localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
   localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TO_LAST[TIMEOUT_W-1:0];

   state_t                state;
   logic [31:0]           pc;
   logic [TIMEOUT_W-1:0]  tcnt;

   assign imem_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         tcnt        <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         halted      <= 1'b0;
         fault       <= '0;
      end else begin
         case (state)
            IDLE: begin
               imem_req <= 1'b1;
               state    <= FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_data;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  tcnt        <= '0;
                  state       <= HOLD;
               end else if (TO_EN && tcnt == TO_LIMIT) begin
                  imem_req <= 1'b0;
                  halted   <= 1'b1;
                  fault    <= FAULT_TIMEOUT;
                  tcnt     <= '0;
                  state    <= HALT;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               if (commit) begin
                  if (flow_exception) begin
                     halted <= 1'b1;
                     fault  <= FAULT_EXC;
                     state  <= HALT;
                  end else begin
`ifdef FETCH_ALIGN_CHECK_EN
                     if (new_pc[1:0] != 2'b00) begin
                        halted <= 1'b1;
                        fault  <= FAULT_ALIGN;
                        state  <= HALT;
                     end else begin
                        pc       <= new_pc;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                     end
`else
                     pc       <= new_pc & ~32'h3;
                     imem_req <= 1'b1;
                     state    <= FETCH;
`endif
                  end
               end
            end
            HALT: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               halted      <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
